pg_loader: RTL and testbench



---
 rtl/pg_loader.sv | 193 +++++++++++++++++++
 tb/tb_pg_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_loader.sv
// rtl/pg_loader.sv - buffers a host byte-stream program and replays it as a burst on the core program port
// Optional checksum byte after the terminator: define PG_LOADER_CHECKSUM_EN.
module pg_loader #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        pg,
    output logic [15:0] pg_instr,
    output logic        cpu_rstz,
    output logic        done,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [15:0] TERM = 16'hF000;

    typedef enum logic [2:0] {
        S_OFF, S_CAPT, S_CSUM, S_DRAIN, S_DRAIN_CS, S_ENTER, S_BURST, S_EXIT
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] n, idx;
    logic          phase;
    logic [7:0]    hi;
    logic [15:0]   mem [DEPTH];

    logic        in_ready_nx, pg_nx, cpu_rstz_nx, done_nx, err_nx, enter;
    logic [15:0] pg_instr_nx, bword;
    logic        xfer, wdone, is_term, wr;

    assign xfer    = in_valid && in_ready;
    assign wdone   = xfer && phase;
    assign is_term = ({hi, in_data} == TERM);
    assign wr      = (state == S_CAPT) && wdone && !is_term && (n != DEPTH_C);
    // The terminator is never stored; it is substituted once the index reaches n.
    assign bword   = (idx == n) ? TERM : mem[idx[AW-1:0]];

`ifdef PG_LOADER_CHECKSUM_EN
    logic [7:0] acc;
    logic       cs_ok;
    assign cs_ok = ((acc ^ in_data) == 8'h00);
`endif

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state    <= S_OFF;
            in_ready <= 1'b0;
            pg       <= 1'b0;
            pg_instr <= 16'h0000;
            cpu_rstz <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            in_ready <= in_ready_nx;
            pg       <= pg_nx;
            pg_instr <= pg_instr_nx;
            cpu_rstz <= cpu_rstz_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        in_ready_nx = in_ready;
        pg_nx       = 1'b0;
        pg_instr_nx = 16'h0000;
        cpu_rstz_nx = cpu_rstz;
        done_nx     = done;
        err_nx      = err;
        enter       = 1'b0;
        case (state)
            S_OFF: begin
                state_nx    = S_CAPT;
                in_ready_nx = 1'b1;
            end
            S_CAPT: begin
                if (wdone) begin
                    if (is_term) begin
`ifdef PG_LOADER_CHECKSUM_EN
                        state_nx = S_CSUM;
`else
                        enter = 1'b1;
`endif
                    end else if (n == DEPTH_C) begin
                        state_nx = S_DRAIN;
                        err_nx   = 1'b1;
                    end
                end
            end
            S_CSUM: begin
`ifdef PG_LOADER_CHECKSUM_EN
                if (xfer) begin
                    if (cs_ok) begin
                        enter = 1'b1;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = S_CAPT;
                    end
                end
`else
                state_nx = S_CAPT;
`endif
            end
            S_DRAIN: begin
                if (wdone && is_term) begin
`ifdef PG_LOADER_CHECKSUM_EN
                    state_nx = S_DRAIN_CS;
`else
                    state_nx = S_CAPT;
`endif
                end
            end
            S_DRAIN_CS: begin
                if (xfer) state_nx = S_CAPT;
            end
            S_ENTER: begin
                state_nx    = S_BURST;
                pg_nx       = 1'b1;
                cpu_rstz_nx = 1'b1;
                pg_instr_nx = bword;
            end
            S_BURST: begin
                if (idx == n + CW'(1)) begin
                    state_nx    = S_EXIT;
                    cpu_rstz_nx = 1'b0;
                end else begin
                    pg_nx       = 1'b1;
                    pg_instr_nx = bword;
                end
            end
            S_EXIT: begin
                state_nx    = S_CAPT;
                cpu_rstz_nx = 1'b1;
                done_nx     = 1'b1;
                in_ready_nx = 1'b1;
            end
            default: state_nx = S_OFF;
        endcase
        if (enter) begin
            state_nx    = S_ENTER;
            pg_nx       = 1'b1;
            cpu_rstz_nx = 1'b0;
            in_ready_nx = 1'b0;
            done_nx     = 1'b0;
            err_nx      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            n     <= '0;
            idx   <= '0;
            phase <= 1'b0;
            hi    <= 8'h00;
`ifdef PG_LOADER_CHECKSUM_EN
            acc   <= 8'h00;
`endif
        end else begin
            if (state == S_ENTER || state == S_BURST) idx <= idx + CW'(1);
            else                                      idx <= '0;
            // Any return to capture starts a fresh program: drop buffer, byte phase, checksum.
            if (state_nx == S_CAPT && state != S_CAPT) begin
                n     <= '0;
                phase <= 1'b0;
`ifdef PG_LOADER_CHECKSUM_EN
                acc   <= 8'h00;
`endif
            end else begin
                if (xfer) begin
                    phase <= ~phase;
                    if (!phase) hi <= in_data;
`ifdef PG_LOADER_CHECKSUM_EN
                    acc <= acc ^ in_data;
`endif
                end
                if (wr) n <= n + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[n[AW-1:0]] <= {hi, in_data};
    end

endmodule

// File: tb/tb_pg_loader.sv
// tb/tb_pg_loader.sv - scoreboard bench for pg_loader with randomized programs against a program-level model
module tb_pg_loader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstz;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, pg, cpu_rstz, done, err;
    logic [15:0] pg_instr;

    pg_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstz(rstz), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pg(pg), .pg_instr(pg_instr),
        .cpu_rstz(cpu_rstz), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected pg=1 cycles, in order: {cpu_rstz, pg_instr}; instr is checked only when cpu_rstz=1.
    logic [16:0] exp_q[$];
    logic [15:0] prog[$];
    logic [7:0]  bytes_q[$];
    bit          exp_done;
    int          gen;
    event        e0_ev;
    int          e0_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [16:0] mon_e;
    always @(negedge clk) begin
        if (rstz === 1'b1 && pg === 1'b1) begin
            chk("no_accept_in_burst", in_ready, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL burst_extra: got %0h expected no pg cycle", {cpu_rstz, pg_instr});
            end else begin
                mon_e = exp_q.pop_front();
                chk("burst_rstz", cpu_rstz, mon_e[16]);
                if (mon_e[16]) chk("burst_word", pg_instr, mon_e[15:0]);
            end
        end
    end

    // Frame timing relative to E0: ENTER, n+1 burst cycles, EXIT, RUN.
    int cn, cg;
    always begin
        @(e0_ev);
        cn = e0_n;
        cg = gen;
        @(negedge clk);
        if (gen == cg) begin
            chk("enter_pg", pg, 1);
            chk("enter_cpu_rstz", cpu_rstz, 0);
            chk("enter_in_ready", in_ready, 0);
            chk("enter_done", done, 0);
            chk("enter_err", err, 0);
        end
        for (int i = 0; i < cn + 2; i++) @(negedge clk);
        if (gen == cg) begin
            chk("exit_pg", pg, 0);
            chk("exit_cpu_rstz", cpu_rstz, 0);
            chk("exit_instr", pg_instr, 0);
        end
        @(negedge clk);
        if (gen == cg) begin
            chk("run_pg", pg, 0);
            chk("run_cpu_rstz", cpu_rstz, 1);
            chk("run_done", done, 1);
            chk("run_in_ready", in_ready, 1);
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: in_ready %0b expected 1 within 300 cycles", in_ready);
            in_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk);
            ok = 1'b1;
        end
    endtask

    task automatic send_program(input bit corrupt);
        logic [7:0] x;
        bit ok, accept;
        bytes_q.delete();
        x = 8'h00;
        foreach (prog[i]) begin
            bytes_q.push_back(prog[i][15:8]);
            bytes_q.push_back(prog[i][7:0]);
        end
        bytes_q.push_back(8'hF0);
        bytes_q.push_back(8'h00);
        foreach (bytes_q[i]) x = x ^ bytes_q[i];
        accept = (prog.size() <= DEPTH);
`ifdef PG_LOADER_CHECKSUM_EN
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        bytes_q.push_back(x);
        if (corrupt) accept = 1'b0;
`endif
        if (accept) begin
            exp_q.push_back(17'h0_0000);
            foreach (prog[i]) exp_q.push_back({1'b1, prog[i]});
            exp_q.push_back({1'b1, 16'hF000});
        end
        foreach (bytes_q[i]) begin
            send_byte(bytes_q[i], ok);
            if (!ok) return;
        end
        if (accept) begin
            e0_n = prog.size();
            -> e0_ev;
            exp_done = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (!accept) begin
            chk("reject_err", err, 1);
            chk("reject_pg", pg, 0);
            chk("reject_done", done, exp_done);
            chk("reject_cpu_rstz", cpu_rstz, exp_done);
            chk("reject_in_ready", in_ready, 1);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pg", pg, 0);
        chk("rst_instr", pg_instr, 0);
        chk("rst_cpu_rstz", cpu_rstz, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic settle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rstz     = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_done = 1'b0;
        gen      = 0;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        rstz = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_cpu_rstz", cpu_rstz, 0);

        prog = '{16'h1234, 16'hA000};
        send_program(1'b0);
        settle();

        prog.delete();
        send_program(1'b0);
        settle();

        prog = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        send_program(1'b0);
        settle();
        prog = '{16'hBEEF};
        send_program(1'b0);
        settle();

        prog = '{16'h1111, 16'h2222, 16'h3333};
        send_program(1'b0);
        prog = '{16'h4444};
        send_program(1'b0);
        settle();

        prog = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        send_program(1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rstz = 1'b0;
        gen++;
        #1;
        check_reset_values();
        exp_q.delete();
        exp_done = 1'b0;
        repeat (2) @(negedge clk);
        rstz = 1'b1;
        send_program(1'b0);
        settle();

`ifdef PG_LOADER_CHECKSUM_EN
        prog = '{16'h1234};
        send_program(1'b1);
        settle();
        send_program(1'b0);
        settle();
`endif

        for (int k = 0; k < 24; k++) begin
            prog.delete();
            for (int j = 0; j < int'($urandom_range(0, DEPTH + 1)); j++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if (w == 16'hF000) w = 16'hF001;
                prog.push_back(w);
            end
            send_program($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) settle();
        end
        settle();
        chk("queue_drained", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
